mdio_peripheral: RTL
====================

MDIO_PERIPHERAL -- requirements
Module: mdio_peripheral

Interface
REQ-001 Parameter PHY_ADDR, default 5'b00001, is the station address this peripheral answers to.
REQ-002 CLK  input  1  system clock; the block uses one clock domain only.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 MDC  input  1  management clock from the controller, sampled on CLK.
REQ-005 MDIO_OE  input  1  controller output enable; high means the controller is driving MDIO_OUT.
REQ-006 MDIO_OUT  input  1  serial data from the controller.
REQ-007 MDIO_IN  output  1  serial read data to the controller.
REQ-008 MDIO_DRV  output  1  high while the peripheral drives MDIO_IN.
REQ-009 ADDR  output  5  register address of the current or last accepted frame.
REQ-010 WR_DATA  output  16  write payload of the last accepted write.
REQ-011 WR_STB  output  1  one-CLK pulse when a write frame completes.
REQ-012 RD_STB  output  1  one-CLK pulse requesting the register contents at ADDR.
REQ-013 RD_DATA  input  16  register contents; valid in the CLK cycle after RD_STB.

Function
REQ-014 The MDC rise event is a CLK cycle where the registered MDC is 0 and the current MDC is 1; the fall event is the inverse of this.
REQ-015 MDIO_OUT is sampled only on rise events; MDIO_IN and MDIO_DRV change only on fall events.
REQ-016 The frame is 32 bits, MSB first, with no preamble: ST[2], OP[2], PHYAD[5], REGAD[5], TA[2], DATA[16].
REQ-017 The states are IDLE, HDR, TA, WDATA, RDATA and SKIP; a 5-bit bit counter indexes bits 0..31.
REQ-018 IDLE: on a rise with MDIO_OE=1, the block samples a 0 and then a 1 on consecutive rises, then goes to HDR with bit count = 2.
REQ-019 In IDLE, a pattern other than 0 followed by 1 restarts start detection; rises with MDIO_OE=0 are ignored.
REQ-020 HDR: the block captures OP at bits 2-3, PHYAD at bits 4-8 and REGAD at bits 9-13; ADDR is updated at bit 13.
REQ-021 At bit 13, if OP is 00 or 11, or if PHYAD is not equal to PHY_ADDR, the block goes to SKIP and ADDR keeps its old value.
REQ-022 Write (OP=01): the block enters TA, ignores bits 14-15 without checking them, then enters WDATA and shifts bits 16-31 into WR_DATA.
REQ-023 On the rise that samples bit 31, WR_DATA is updated and WR_STB pulses in the next CLK cycle; the block then returns to IDLE.
REQ-024 Read (OP=10): RD_STB pulses in the CLK cycle after the bit-13 rise; RD_DATA is loaded into the TX shift register one cycle later.
REQ-025 Read: on the fall after bit 14, MDIO_DRV=1 and MDIO_IN=0 (second TA bit).
REQ-026 Read: on each following fall, MDIO_IN carries data bits 15..0 in order.
REQ-027 Read: on the fall after the bit-31 rise, MDIO_DRV=0 and MDIO_IN=0, and the block goes to IDLE.
REQ-028 MDIO_DRV is high for exactly 17 MDC periods per read.
REQ-029 SKIP: the block counts rises up to bit 31 and then goes to IDLE; start patterns seen inside SKIP are ignored.
REQ-030 In WDATA or HDR, MDIO_OE=0 on a rise aborts the frame to IDLE with no strobe; in RDATA, MDIO_OE is not checked.
REQ-031 Back-to-back frames: a new ST can be detected on the first rise after the block returns to IDLE.
REQ-032 WR_STB and RD_STB are never high in the same cycle; at most one strobe of each kind is issued per frame.

Reset
REQ-033 When RESET=1 on a CLK edge, the state is IDLE, the bit counter and shift registers are 0, and MDIO_IN=0, MDIO_DRV=0, ADDR=0, WR_DATA=0, WR_STB=0, RD_STB=0.
REQ-034 A reset during any frame takes effect on the next CLK edge, discards the frame and issues no strobe.
REQ-035 After reset is released, the block needs a fresh ST pattern before it accepts a frame.

Structure
REQ-036 Package mdio_pkg holds the OP_WRITE and OP_READ constants, the ST pattern, the field widths and bit positions, and the state encoding; the controller shares this package.
REQ-037 Sub-module mdc_edge_detect (input MDC; outputs rise and fall pulses) is instantiated once.

Verification
REQ-038 Write: PHYAD=1, REGAD=2, DATA=16'h3C33 -> exactly one WR_STB, with ADDR=2, WR_DATA=16'h3C33, and MDIO_DRV=0 throughout.
REQ-039 Read: PHYAD=1, REGAD=4, RD_DATA=16'hA5C3 -> one RD_STB with ADDR=4; MDIO_IN shows 0 then 1010010111000011; MDIO_DRV is high for 17 MDC periods.
REQ-040 PHY mismatch: a write to PHYAD=3 -> no strobe, ADDR unchanged, MDIO_DRV=0; a following write to PHYAD=1 is accepted.
REQ-041 Invalid op: OP=11 -> SKIP for the remaining 18 bits, no strobe, then a back-to-back valid write is accepted.
REQ-042 Reset mid-read: RESET pulsed at data bit 20 -> MDIO_DRV=0 and MDIO_IN=0 on the next CLK edge; no WR_STB is issued.
REQ-043 Write abort: MDIO_OE falls at bit 24 -> no WR_STB, WR_DATA keeps its old value, and the state returns to IDLE.

Source files
------------

// File: rtl/mdio_pkg.sv
// mdio_pkg: frame layout, opcodes and FSM encoding shared by the MDIO peripheral and controller
package mdio_pkg;
  localparam int OP_W   = 2;
  localparam int PHY_W  = 5;
  localparam int REG_W  = 5;
  localparam int DATA_W = 16;
  localparam int HDR_W  = OP_W + PHY_W + REG_W;
  localparam logic [1:0] ST_PATTERN = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [4:0] BIT_OP       = 5'd2;
  localparam logic [4:0] BIT_REG_LAST = 5'd13;
  localparam logic [4:0] BIT_TA_LAST  = 5'd15;
  localparam logic [4:0] CNT_RD_TA    = 5'd15;
  localparam logic [4:0] BIT_LAST     = 5'd31;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_TA    = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_SKIP  = 3'd5;
endpackage

// File: rtl/mdio_peripheral_if.sv
// mdio_peripheral_if: MDIO serial lines plus the register-side strobe/data bus
interface mdio_peripheral_if;
  logic        MDC;
  logic        MDIO_OE;
  logic        MDIO_OUT;
  logic        MDIO_IN;
  logic        MDIO_DRV;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic        RD_STB;
  logic [15:0] RD_DATA;
  modport slave (
    input  MDC, MDIO_OE, MDIO_OUT, RD_DATA,
    output MDIO_IN, MDIO_DRV, ADDR, WR_DATA, WR_STB, RD_STB
  );
  modport master (
    output MDC, MDIO_OE, MDIO_OUT, RD_DATA,
    input  MDIO_IN, MDIO_DRV, ADDR, WR_DATA, WR_STB, RD_STB
  );
endinterface

// File: rtl/mdc_edge_detect.sv
// mdc_edge_detect: single-cycle rise/fall pulses of MDC in the CLK domain
module mdc_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  output logic rise,
  output logic fall
);
  logic mdc_q;
  // previous MDC sample, compared against the live level
  always_ff @(posedge clk)
    if (rst) mdc_q <= 1'b0;
    else mdc_q <= mdc;
  assign rise = mdc & ~mdc_q;
  assign fall = ~mdc & mdc_q;
endmodule

// File: rtl/mdio_peripheral.sv
// mdio_peripheral: preamble-less clause-22 MDIO station exposing a register strobe interface
module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'b00001
) (
  input logic CLK,
  input logic RESET,
  mdio_peripheral_if.slave bus
);
  logic              rise, fall;
  logic [2:0]        state;
  logic [4:0]        cnt;
  logic              st_seen;
  logic              is_rd;
  logic              rd_pend;
  logic [HDR_W-1:0]  hdr, hdr_n;
  logic [DATA_W-1:0] wsr, wsr_n, tx;
  logic              hdr_ok;
  mdc_edge_detect u_edge (.clk(CLK), .rst(RESET), .mdc(bus.MDC), .rise(rise), .fall(fall));
  assign hdr_n  = {hdr[HDR_W-2:0], bus.MDIO_OUT};
  assign wsr_n  = {wsr[DATA_W-2:0], bus.MDIO_OUT};
  assign hdr_ok = (hdr_n[HDR_W-1 -: OP_W] == OP_WRITE || hdr_n[HDR_W-1 -: OP_W] == OP_READ)
                  && hdr_n[REG_W +: PHY_W] == PHY_ADDR;
  // frame FSM: sample controller bits on MDC rise, drive read data on MDC fall
  always_ff @(posedge CLK)
    if (RESET) begin
      state        <= S_IDLE;
      cnt          <= '0;
      st_seen      <= 1'b0;
      is_rd        <= 1'b0;
      rd_pend      <= 1'b0;
      hdr          <= '0;
      wsr          <= '0;
      tx           <= '0;
      bus.MDIO_IN  <= 1'b0;
      bus.MDIO_DRV <= 1'b0;
      bus.ADDR     <= '0;
      bus.WR_DATA  <= '0;
      bus.WR_STB   <= 1'b0;
      bus.RD_STB   <= 1'b0;
    end else begin
      bus.WR_STB <= 1'b0;
      bus.RD_STB <= 1'b0;
      rd_pend    <= bus.RD_STB;
      if (rd_pend) tx <= bus.RD_DATA;
      if (rise)
        case (state)
          S_IDLE:
            if (bus.MDIO_OE) begin
              if (st_seen && bus.MDIO_OUT == ST_PATTERN[0]) begin
                state   <= S_HDR;
                cnt     <= BIT_OP;
                st_seen <= 1'b0;
              end else st_seen <= bus.MDIO_OUT == ST_PATTERN[1];
            end
          S_HDR:
            if (!bus.MDIO_OE) state <= S_IDLE;
            else begin
              hdr <= hdr_n;
              cnt <= cnt + 5'd1;
              if (cnt == BIT_REG_LAST) begin
                state      <= hdr_ok ? S_TA : S_SKIP;
                is_rd      <= hdr_n[HDR_W-1 -: OP_W] == OP_READ;
                bus.RD_STB <= hdr_ok && hdr_n[HDR_W-1 -: OP_W] == OP_READ;
                if (hdr_ok) bus.ADDR <= hdr_n[REG_W-1:0];
              end
            end
          S_TA: begin
            cnt <= cnt + 5'd1;
            if (is_rd) state <= S_RDATA;
            else if (cnt == BIT_TA_LAST) state <= S_WDATA;
          end
          S_WDATA:
            if (!bus.MDIO_OE) state <= S_IDLE;
            else begin
              wsr <= wsr_n;
              cnt <= cnt + 5'd1;
              if (cnt == BIT_LAST) begin
                bus.WR_DATA <= wsr_n;
                bus.WR_STB  <= 1'b1;
                state       <= S_IDLE;
              end
            end
          S_RDATA: cnt <= cnt + 5'd1;
          S_SKIP: begin
            cnt <= cnt + 5'd1;
            if (cnt == BIT_LAST) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      if (fall && state == S_RDATA) begin
        if (cnt == CNT_RD_TA) begin
          bus.MDIO_DRV <= 1'b1;
          bus.MDIO_IN  <= 1'b0;
        end else if (cnt == 5'd0) begin
          bus.MDIO_DRV <= 1'b0;
          bus.MDIO_IN  <= 1'b0;
          state        <= S_IDLE;
        end else begin
          bus.MDIO_IN <= tx[DATA_W-1];
          tx          <= {tx[DATA_W-2:0], 1'b0};
        end
      end
    end
endmodule
